rpn_stack_ctrl: RTL and testbench

Sequencing controller for the RPN calculator datapath: stack RAM, stack pointer, operand registers A/B and the combinational ALU. It accepts one command at a time (push, drop, clear, binary ALU op) over a valid/ready handshake. It drives RAM address, write strobe and write data, the A/B load enables and ALU_OP. It also maintains SP, a top-of-stack copy and sticky error flags for the HEX/LEDR display logic.

---
 rtl/rpn_stack_ctrl_pkg.sv | 45 ++++
 rtl/rpn_stack_ctrl_if.sv | 23 ++
 rtl/rpn_stack_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_stack_ctrl_pkg.sv
// Shared definitions for the RPN stack controller: command codes, FSM states, ALU op codes.
package rpn_stack_ctrl_pkg;

  localparam int unsigned CMD_OP_W = 2;
  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [CMD_OP_W-1:0] {
    CMD_PUSH  = 2'd0,
    CMD_DROP  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_BINOP = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PUSH    = 4'd1,
    ST_RD_B    = 4'd2,
    ST_LD_B    = 4'd3,
    ST_RD_A    = 4'd4,
    ST_LD_A    = 4'd5,
    ST_WB      = 4'd6,
    ST_DROP_RD = 4'd7,
    ST_DROP_LD = 4'd8,
    ST_RETIRE  = 4'd9
  } state_e;

  // ALU_OP codes shared with the ALU; the controller passes them through untouched.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_SHL    = 3'd5,
    ALU_SHR    = 3'd6,
    ALU_PASS_A = 3'd7
  } alu_op_e;

  // Command header as seen on the handshake (operand travels separately, its width is a parameter).
  typedef struct packed {
    cmd_op_e               op;
    logic [ALU_OP_W-1:0]   alu_op;
  } cmd_hdr_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Command handshake between the front panel decoder (master) and the stack controller (slave).
interface rpn_stack_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  import rpn_stack_ctrl_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [CMD_OP_W-1:0] cmd_op;
  logic [ALU_OP_W-1:0] cmd_alu_op;
  logic [DATA_W-1:0]   cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_alu_op, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_alu_op, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/rpn_stack_ctrl.sv
// RPN calculator sequencer: walks the stack RAM / A,B load / ALU writeback for one command at a time
// and keeps SP, a top-of-stack shadow and sticky error flags for the display.
module rpn_stack_ctrl
  import rpn_stack_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  rpn_stack_ctrl_if.slave     cmd,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                load_A,
  output logic                load_B,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [ADDR_W-1:0]   sp,
  output logic [DATA_W-1:0]   tos,
  output logic                done,
  output logic                err_ovf,
  output logic                err_unf
);

  localparam logic [ADDR_W-1:0] SP_FULL = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SP_TWO  = ADDR_W'(2);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0]   tos_q, tos_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ALU_OP_W-1:0] aop_q, aop_d;
  logic [DATA_W-1:0]   data_q, data_d;
  cmd_hdr_t            hdr_in;

  assign hdr_in = '{op: cmd_op_e'(cmd.cmd_op), alu_op: cmd.cmd_alu_op};

  // Reset must park everything, including the write strobe, without waiting for a clock.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      tos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      aop_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      tos_q   <= tos_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      aop_q   <= aop_d;
      data_q  <= data_d;
    end
  end

  // Next state, register updates and state-decoded RAM/ALU controls.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    tos_d     = tos_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    aop_d     = aop_q;
    data_d    = data_q;
    ram_addr  = sp_q;
    ram_we    = 1'b0;
    ram_wdata = data_q;
    load_A    = 1'b0;
    load_B    = 1'b0;
    alu_op    = aop_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          aop_d  = hdr_in.alu_op;
          data_d = cmd.cmd_data;
          unique case (hdr_in.op)
            CMD_PUSH: begin
              if (sp_q == SP_FULL) begin
                ovf_d   = 1'b1;
                state_d = ST_RETIRE;
              end else begin
                state_d = ST_PUSH;
              end
            end
            CMD_DROP: begin
              if (sp_q == '0) begin
                unf_d   = 1'b1;
                state_d = ST_RETIRE;
              end else begin
                state_d = ST_DROP_RD;
              end
            end
            CMD_CLEAR: begin
              sp_d    = '0;
              tos_d   = '0;
              ovf_d   = 1'b0;
              unf_d   = 1'b0;
              state_d = ST_RETIRE;
            end
            CMD_BINOP: begin
              if (sp_q < SP_TWO) begin
                unf_d   = 1'b1;
                state_d = ST_RETIRE;
              end else begin
                state_d = ST_RD_B;
              end
            end
            default: state_d = ST_RETIRE;
          endcase
        end
      end
      ST_PUSH: begin
        ram_we  = 1'b1;
        sp_d    = sp_q + SP_ONE;
        tos_d   = data_q;
        state_d = ST_RETIRE;
      end
      ST_RD_B: begin
        ram_addr = sp_q - SP_ONE;
        state_d  = ST_LD_B;
      end
      ST_LD_B: begin
        ram_addr = sp_q - SP_ONE;
        load_B   = 1'b1;
        state_d  = ST_RD_A;
      end
      ST_RD_A: begin
        ram_addr = sp_q - SP_TWO;
        state_d  = ST_LD_A;
      end
      ST_LD_A: begin
        ram_addr = sp_q - SP_TWO;
        load_A   = 1'b1;
        state_d  = ST_WB;
      end
      ST_WB: begin
        ram_addr  = sp_q - SP_TWO;
        ram_we    = 1'b1;
        ram_wdata = alu_result;
        sp_d      = sp_q - SP_ONE;
        tos_d     = alu_result;
        state_d   = ST_RETIRE;
      end
      // A single entry has no successor to expose, so it skips the read and empties directly.
      ST_DROP_RD: begin
        ram_addr = sp_q - SP_TWO;
        if (sp_q == SP_ONE) begin
          sp_d    = '0;
          tos_d   = '0;
          state_d = ST_RETIRE;
        end else begin
          state_d = ST_DROP_LD;
        end
      end
      ST_DROP_LD: begin
        tos_d   = ram_rdata;
        sp_d    = sp_q - SP_ONE;
        state_d = ST_RETIRE;
      end
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign done          = (state_q == ST_RETIRE);
  assign sp            = sp_q;
  assign tos           = tos_q;
  assign err_ovf       = ovf_q;
  assign err_unf       = unf_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl with a behavioural stack RAM, A/B registers and ALU.
module tb_rpn_stack_ctrl;
  import rpn_stack_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ram_addr, ram_wdata, ram_rdata, alu_result, sp, tos;
  logic       ram_we, load_A, load_B, done, err_ovf, err_unf;
  logic [2:0] alu_op;

  rpn_stack_ctrl_if #(.DATA_W(8)) cmd_if ();

  rpn_stack_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .cmd       (cmd_if),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .load_A    (load_A),
    .load_B    (load_B),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .sp        (sp),
    .tos       (tos),
    .done      (done),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #10 clk = ~clk;

  // Environment: synchronous-read RAM, operand registers, combinational ALU.
  logic [7:0] mem [256];
  logic [7:0] reg_a = 8'h00, reg_b = 8'h00;
  int         we_total = 0;

  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_wdata;
      we_total      <= we_total + 1;
    end
    ram_rdata <= mem[ram_addr];
    if (load_A === 1'b1) reg_a <= ram_rdata;
    if (load_B === 1'b1) reg_b <= ram_rdata;
  end

  always_comb begin
    case (alu_op)
      3'd0:    alu_result = reg_a + reg_b;
      3'd1:    alu_result = reg_a - reg_b;
      3'd2:    alu_result = reg_a & reg_b;
      3'd3:    alu_result = reg_a | reg_b;
      3'd4:    alu_result = reg_a ^ reg_b;
      default: alu_result = reg_a;
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [2:0] aop;
    logic [7:0] data;
    logic [7:0] exp_sp;
    logic [7:0] exp_tos;
    logic       exp_ovf;
    logic       exp_unf;
    int         exp_lat;
    int         exp_we;
    int         mem_addr;
    logic [7:0] mem_exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void addv(input logic [1:0] op, input logic [2:0] aop, input logic [7:0] d,
                               input logic [7:0] esp, input logic [7:0] etos,
                               input logic eo, input logic eu, input int lat, input int we,
                               input int maddr = -1, input logic [7:0] mexp = 8'h00);
    vec_t v;
    v = '{op: op, aop: aop, data: d, exp_sp: esp, exp_tos: etos, exp_ovf: eo, exp_unf: eu,
          exp_lat: lat, exp_we: we, mem_addr: maddr, mem_exp: mexp};
    vecs.push_back(v);
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (cmd_if.cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    int    lat;
    int    we0;
    nm = $sformatf("v%0d", idx);
    wait_ready(nm);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = v.op;
    cmd_if.cmd_alu_op = v.aop;
    cmd_if.cmd_data   = v.data;
    we0 = we_total;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_op     = 2'($urandom_range(3, 0));
    cmd_if.cmd_data   = 8'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_sp"}, 32'(sp), 32'(v.exp_sp));
    chk({nm, "_tos"}, 32'(tos), 32'(v.exp_tos));
    chk({nm, "_err_ovf"}, 32'(err_ovf), 32'(v.exp_ovf));
    chk({nm, "_err_unf"}, 32'(err_unf), 32'(v.exp_unf));
    chk({nm, "_ram_we_count"}, 32'(we_total - we0), 32'(v.exp_we));
    if (v.mem_addr >= 0) chk({nm, "_ram"}, 32'(mem[v.mem_addr]), 32'(v.mem_exp));
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_op     = 2'd0;
    cmd_if.cmd_alu_op = 3'd0;
    cmd_if.cmd_data   = 8'h00;

    // Directed command table: op, alu_op, data, sp, tos, ovf, unf, latency, writes [, ram addr, ram value]
    addv(CMD_PUSH,  ALU_ADD, 8'h05, 8'd1, 8'h05, 0, 0, 2, 1);
    addv(CMD_PUSH,  ALU_ADD, 8'h03, 8'd2, 8'h03, 0, 0, 2, 1);
    addv(CMD_BINOP, ALU_ADD, 8'h00, 8'd1, 8'h08, 0, 0, 6, 1, 0, 8'h08);
    addv(CMD_CLEAR, ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 0, 1, 0);
    addv(CMD_PUSH,  ALU_ADD, 8'hF0, 8'd1, 8'hF0, 0, 0, 2, 1);
    addv(CMD_PUSH,  ALU_ADD, 8'h20, 8'd2, 8'h20, 0, 0, 2, 1);
    addv(CMD_BINOP, ALU_ADD, 8'h00, 8'd1, 8'h10, 0, 0, 6, 1, 0, 8'h10);
    addv(CMD_PUSH,  ALU_ADD, 8'h09, 8'd2, 8'h09, 0, 0, 2, 1);
    addv(CMD_BINOP, ALU_SUB, 8'h00, 8'd1, 8'h07, 0, 0, 6, 1, 0, 8'h07);
    addv(CMD_PUSH,  ALU_ADD, 8'h03, 8'd2, 8'h03, 0, 0, 2, 1);
    addv(CMD_BINOP, ALU_SUB, 8'h00, 8'd1, 8'h04, 0, 0, 6, 1, 0, 8'h04);
    addv(CMD_PUSH,  ALU_ADD, 8'h09, 8'd2, 8'h09, 0, 0, 2, 1);
    addv(CMD_BINOP, ALU_SUB, 8'h00, 8'd1, 8'hFB, 0, 0, 6, 1, 0, 8'hFB);
    addv(CMD_BINOP, ALU_ADD, 8'h00, 8'd1, 8'hFB, 0, 1, 1, 0);
    addv(CMD_CLEAR, ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 0, 1, 0);
    addv(CMD_DROP,  ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 1, 1, 0);
    addv(CMD_BINOP, ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 1, 1, 0);
    addv(CMD_PUSH,  ALU_ADD, 8'h07, 8'd1, 8'h07, 0, 1, 2, 1);
    addv(CMD_CLEAR, ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 0, 1, 0);
    for (int i = 1; i <= 16; i++)
      addv(CMD_PUSH, ALU_ADD, 8'(i), 8'(i), 8'(i), 0, 0, 2, 1, i - 1, 8'(i));
    addv(CMD_PUSH,  ALU_ADD, 8'hAA, 8'd16, 8'h10, 1, 0, 1, 0, 15, 8'h10);
    addv(CMD_CLEAR, ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 0, 1, 0);
    addv(CMD_PUSH,  ALU_ADD, 8'h11, 8'd1, 8'h11, 0, 0, 2, 1);
    addv(CMD_PUSH,  ALU_ADD, 8'h22, 8'd2, 8'h22, 0, 0, 2, 1);
    addv(CMD_DROP,  ALU_ADD, 8'h00, 8'd1, 8'h11, 0, 0, 3, 0);
    addv(CMD_DROP,  ALU_ADD, 8'h00, 8'd0, 8'h00, 0, 0, 2, 0);
    addv(CMD_PUSH,  ALU_ADD, 8'h3C, 8'd1, 8'h3C, 0, 0, 2, 1);
    addv(CMD_PUSH,  ALU_ADD, 8'h0F, 8'd2, 8'h0F, 0, 0, 2, 1);
    addv(CMD_BINOP, ALU_AND, 8'h00, 8'd1, 8'h0C, 0, 0, 6, 1, 0, 8'h0C);
    addv(CMD_PUSH,  ALU_ADD, 8'h01, 8'd2, 8'h01, 0, 0, 2, 1);

    // Values held while reset is asserted.
    #5;
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_tos", 32'(tos), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_flags", 32'({err_ovf, err_unf}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset asserted mid-BINOP, in the LD_A cycle, between clock edges.
    wait_ready("arst");
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = CMD_BINOP;
    cmd_if.cmd_alu_op = ALU_ADD;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_load_A_before", 32'(load_A), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_load_A", 32'(load_A), 32'd0);
    chk("arst_ram_we", 32'(ram_we), 32'd0);
    chk("arst_sp", 32'(sp), 32'd0);
    chk("arst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready_after", 32'(cmd_if.cmd_ready), 32'd1);
    chk("arst_sp_after", 32'(sp), 32'd0);
    chk("arst_tos_after", 32'(tos), 32'd0);
    chk("arst_flags_after", 32'({err_ovf, err_unf}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
